// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with look-ahead pixel
// coordinates, a matched sync/active delay line and a registered, blanked
// RGB output stage. Everything advances only on pixel-enable ticks.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1440,
  parameter int H_FP      = 80,
  parameter int H_SYNC    = 152,
  parameter int H_BP      = 232,
  parameter int V_ACTIVE  = 900,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 28,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b1,
  parameter int CW        = 4,
  parameter int LOOKAHEAD = 1,
  parameter int XW        = 11,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic [CW-1:0] red_in,
  input  logic [CW-1:0] gre_in,
  input  logic [CW-1:0] blu_in,
  output logic [CW-1:0] pix_r,
  output logic [CW-1:0] pix_g,
  output logic [CW-1:0] pix_b,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] curr_x,
  output logic [YW-1:0] curr_y,
  output logic          coord_valid,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [31:0]   h_pos;
  logic [31:0]   v_pos;
  logic          h_last;
  logic          v_last;
  logic          h_act;
  logic          v_act;
  logic          hsync_i;
  logic          vsync_i;
  logic          active_i;
  logic [2:0]    raw_bus;
  logic [2:0]    dly_bus;
  logic          dly_hs;
  logic          dly_vs;
  logic          dly_act;

  // Counters widened to 32 bits so window bounds equal to a power of two
  // never alias to zero when compared.
  assign h_pos  = 32'(hcount);
  assign v_pos  = 32'(vcount);
  assign h_last = (h_pos == 32'(H_TOTAL - 1));
  assign v_last = (v_pos == 32'(V_TOTAL - 1));

  // Pixel and line counters; the line counter steps when the pixel counter wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  // Issue stage: raw timing flags, visible coordinates and tick-qualified strobes
  always_comb begin
    h_act       = (h_pos >= 32'(H_START)) && (h_pos < 32'(H_END));
    v_act       = (v_pos >= 32'(V_START)) && (v_pos < 32'(V_END));
    hsync_i     = (h_pos < 32'(H_SYNC));
    vsync_i     = (v_pos < 32'(V_SYNC));
    active_i    = h_act && v_act;
    coord_valid = active_i;
    curr_x      = '0;
    curr_y      = '0;
    if (active_i) begin
      curr_x = XW'(h_pos - 32'(H_START));
      curr_y = YW'(v_pos - 32'(V_START));
    end
    line_start  = active_i && (curr_x == '0) && pix_en;
    frame_start = active_i && (curr_x == '0) && (curr_y == '0) && pix_en;
  end

  assign raw_bus = {hsync_i, vsync_i, active_i};

  // The delay line gives the renderer LOOKAHEAD ticks between seeing a
  // coordinate and presenting its colour; syncs ride along so their relation
  // to colour is independent of the look-ahead depth.
  generate
    if (LOOKAHEAD == 0) begin : g_no_delay
      assign dly_bus = raw_bus;
    end else begin : g_delay
      logic [2:0] pipe [LOOKAHEAD];

      // Shift raw flags one stage per pixel tick; reset clears to inactive
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LOOKAHEAD; i++) pipe[i] <= '0;
        end else if (pix_en) begin
          pipe[0] <= raw_bus;
          for (int i = 1; i < LOOKAHEAD; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_bus = pipe[LOOKAHEAD-1];
    end
  endgenerate

  assign dly_hs  = dly_bus[2];
  assign dly_vs  = dly_bus[1];
  assign dly_act = dly_bus[0];

  // Output register: apply sync polarity and blank colour outside the active area
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
    end else if (pix_en) begin
      hsync <= dly_hs ? HS_POL : ~HS_POL;
      vsync <= dly_vs ? VS_POL : ~VS_POL;
      de    <= dly_act;
      pix_r <= dly_act ? red_in : '0;
      pix_g <= dly_act ? gre_in : '0;
      pix_b <= dly_act ? blu_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen in three configurations:
// a tiny frame with an exact per-tick reference, a look-ahead-2 frame fed by a
// two-stage renderer, and the default 1440x900 timing up to the first frame.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Free-running system clock
  always #5 clk = ~clk;

  // ---------------- instance A: tiny frame, look-ahead 0 ----------------
  logic       rst_n_a, pix_en_a;
  logic [3:0] red_in_a, gre_in_a, blu_in_a;
  logic [3:0] pix_r_a, pix_g_a, pix_b_a;
  logic       hsync_a, vsync_a, de_a, coord_valid_a, frame_start_a, line_start_a;
  logic [10:0] curr_x_a;
  logic [9:0]  curr_y_a;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .LOOKAHEAD(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_en(pix_en_a),
    .red_in(red_in_a), .gre_in(gre_in_a), .blu_in(blu_in_a),
    .pix_r(pix_r_a), .pix_g(pix_g_a), .pix_b(pix_b_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .curr_x(curr_x_a), .curr_y(curr_y_a), .coord_valid(coord_valid_a),
    .frame_start(frame_start_a), .line_start(line_start_a)
  );

  // ---------------- instance B: 26x6 frame, look-ahead 2 ----------------
  logic       rst_n_b, pix_en_b;
  logic [3:0] red_in_b, gre_in_b, blu_in_b;
  logic [3:0] pix_r_b, pix_g_b, pix_b_b;
  logic       hsync_b, vsync_b, de_b, coord_valid_b, frame_start_b, line_start_b;
  logic [10:0] curr_x_b;
  logic [9:0]  curr_y_b;
  logic [3:0] rb1, rb2;

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .LOOKAHEAD(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pix_en(pix_en_b),
    .red_in(red_in_b), .gre_in(gre_in_b), .blu_in(blu_in_b),
    .pix_r(pix_r_b), .pix_g(pix_g_b), .pix_b(pix_b_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .curr_x(curr_x_b), .curr_y(curr_y_b), .coord_valid(coord_valid_b),
    .frame_start(frame_start_b), .line_start(line_start_b)
  );

  // Renderer stand-in: colour is curr_x[3:0] delayed two pixel ticks
  always @(posedge clk) begin
    if (pix_en_b) begin
      rb1 <= curr_x_b[3:0];
      rb2 <= rb1;
    end
  end
  assign red_in_b = rb2;

  // ---------------- instance C: default 1904x932 timing ----------------
  logic       rst_n_c, pix_en_c;
  logic [3:0] red_in_c, gre_in_c, blu_in_c;
  logic [3:0] pix_r_c, pix_g_c, pix_b_c;
  logic       hsync_c, vsync_c, de_c, coord_valid_c, frame_start_c, line_start_c;
  logic [10:0] curr_x_c;
  logic [9:0]  curr_y_c;

  vga_timing_gen dut_c (
    .clk(clk), .rst_n(rst_n_c), .pix_en(pix_en_c),
    .red_in(red_in_c), .gre_in(gre_in_c), .blu_in(blu_in_c),
    .pix_r(pix_r_c), .pix_g(pix_g_c), .pix_b(pix_b_c),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c),
    .curr_x(curr_x_c), .curr_y(curr_y_c), .coord_valid(coord_valid_c),
    .frame_start(frame_start_c), .line_start(line_start_c)
  );

  // ---------------- checking ----------------
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference state for instance A (line 14 ticks, frame 7 lines)
  int         ma_h, ma_v;
  logic       ea_hs, ea_vs, ea_de;
  logic [3:0] ea_r, ea_gb;
  bit         cnt_on;
  int         ca_hs, ca_vs, ca_de, ca_ls, ca_fs;

  // One clock of instance A: drive, check against reference, advance reference
  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [3:0] red_v);
    logic act;
    rst_n_a  = rst_v;
    pix_en_a = en_v;
    red_in_a = red_v;
    #2;
    act = (ma_h >= 4) && (ma_h < 12) && (ma_v >= 2) && (ma_v < 6);
    checkOutput("a_cv", coord_valid_a, act);
    checkOutput("a_x", curr_x_a, act ? ma_h - 4 : 0);
    checkOutput("a_y", curr_y_a, act ? ma_v - 2 : 0);
    checkOutput("a_ls", line_start_a, act && (ma_h == 4) && en_v);
    checkOutput("a_fs", frame_start_a, act && (ma_h == 4) && (ma_v == 2) && en_v);
    checkOutput("a_hs", hsync_a, ea_hs);
    checkOutput("a_vs", vsync_a, ea_vs);
    checkOutput("a_de", de_a, ea_de);
    checkOutput("a_r", pix_r_a, ea_r);
    checkOutput("a_gb", {pix_g_a, pix_b_a}, {ea_gb, ea_gb});
    if (cnt_on) begin
      if (hsync_a) ca_hs++;
      if (!vsync_a) ca_vs++;
      if (de_a) ca_de++;
      if (line_start_a) ca_ls++;
      if (frame_start_a) ca_fs++;
    end
    @(posedge clk);
    if (!rst_v) begin
      ma_h = 0; ma_v = 0;
      ea_hs = 1'b0; ea_vs = 1'b1; ea_de = 1'b0; ea_r = 4'h0; ea_gb = 4'h0;
    end else if (en_v) begin
      ea_hs = (ma_h < 3);
      ea_vs = (ma_v < 1) ? 1'b0 : 1'b1;
      ea_de = act;
      ea_r  = act ? red_v : 4'h0;
      ea_gb = act ? 4'hF : 4'h0;
      if (ma_h == 13) begin
        ma_h = 0;
        ma_v = (ma_v == 6) ? 0 : ma_v + 1;
      end else begin
        ma_h++;
      end
    end
    #1;
  endtask

  // Measurement state for instance B
  int kb, run_b, runs_b, cb_hs, cb_vs, de_first, hs_first;
  bit fs_b;

  // One clock of instance B: colour/blanking per tick plus timing measurements
  task automatic applyStimulusLook(input logic rst_v);
    rst_n_b  = rst_v;
    pix_en_b = 1'b1;
    #2;
    fs_b = frame_start_b;
    if (de_b) begin
      checkOutput("b_pix_r", pix_r_b, run_b % 16);
      checkOutput("b_pix_gb", {pix_g_b, pix_b_b}, 8'hFF);
      run_b++;
      if (de_first < 0) de_first = kb;
    end else begin
      checkOutput("b_blank", {pix_r_b, pix_g_b, pix_b_b}, 0);
      if (run_b != 0) begin
        checkOutput("b_run", run_b, 20);
        runs_b++;
        run_b = 0;
      end
    end
    if (!hsync_b && hs_first < 0) hs_first = kb;
    if (kb >= 3 && kb < 159) begin
      if (!hsync_b) cb_hs++;
      if (vsync_b) cb_vs++;
    end
    kb++;
    @(posedge clk);
    #1;
  endtask

  task automatic clearLook();
    kb = 0; run_b = 0; runs_b = 0; cb_hs = 0; cb_vs = 0;
    de_first = -1; hs_first = -1; fs_b = 1'b0;
  endtask

  // Main sequence
  initial begin
    int hs_c, vs_c, de_c_cnt, dfirst_c, ffirst_c;
    rst_n_a = 0; rst_n_b = 0; rst_n_c = 0;
    pix_en_a = 1; pix_en_b = 1; pix_en_c = 1;
    red_in_a = 0; gre_in_a = 4'hF; blu_in_a = 4'hF;
    gre_in_b = 4'hF; blu_in_b = 4'hF;
    red_in_c = 4'hF; gre_in_c = 4'hF; blu_in_c = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    ma_h = 0; ma_v = 0;
    ea_hs = 1'b0; ea_vs = 1'b1; ea_de = 1'b0; ea_r = 4'h0; ea_gb = 4'h0;
    cnt_on = 0; ca_hs = 0; ca_vs = 0; ca_de = 0; ca_ls = 0; ca_fs = 0;

    $display("[TB] instance A: two frames at full rate");
    applyStimulus(1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'h0);
    applyStimulus(1'b1, 1'b1, 4'h0);
    cnt_on = 1;
    for (int c = 1; c <= 196; c++) applyStimulus(1'b1, 1'b1, 4'(c));
    cnt_on = 0;
    checkOutput("a_hs_cnt", ca_hs, 42);
    checkOutput("a_vs_cnt", ca_vs, 28);
    checkOutput("a_de_cnt", ca_de, 64);
    checkOutput("a_ls_cnt", ca_ls, 8);
    checkOutput("a_fs_cnt", ca_fs, 2);

    $display("[TB] instance A: pix_en one tick in four");
    applyStimulus(1'b0, 1'b0, 4'h0);
    ca_hs = 0; ca_vs = 0; ca_de = 0; ca_ls = 0; ca_fs = 0;
    applyStimulus(1'b1, 1'b1, 4'h0);
    cnt_on = 1;
    for (int c = 1; c <= 784; c++) applyStimulus(1'b1, (c % 4) == 0, 4'(c));
    cnt_on = 0;
    checkOutput("a4_hs_cnt", ca_hs, 168);
    checkOutput("a4_vs_cnt", ca_vs, 112);
    checkOutput("a4_de_cnt", ca_de, 256);
    checkOutput("a4_ls_cnt", ca_ls, 8);
    checkOutput("a4_fs_cnt", ca_fs, 2);

    $display("[TB] instance B: look-ahead 2, two frames");
    clearLook();
    for (int i = 0; i < 312; i++) applyStimulusLook(1'b1);
    checkOutput("b_runs", runs_b, 6);
    checkOutput("b_hs_first", hs_first, 3);
    checkOutput("b_de_first", de_first, 59);
    checkOutput("b_hs_cnt", cb_hs, 12);
    checkOutput("b_vs_cnt", cb_vs, 26);
    for (int i = 0; i < 90; i++) applyStimulusLook(1'b1);

    $display("[TB] instance B: reset mid-line, held three cycles");
    rst_n_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("b_rst_hs", hsync_b, 1'b1);
      checkOutput("b_rst_vs", vsync_b, 1'b0);
      checkOutput("b_rst_de", de_b, 1'b0);
      checkOutput("b_rst_pix", {pix_r_b, pix_g_b, pix_b_b}, 0);
      checkOutput("b_rst_xy", {curr_x_b, curr_y_b}, 0);
      checkOutput("b_rst_strb", {coord_valid_b, frame_start_b, line_start_b}, 0);
    end
    clearLook();
    while (!fs_b && kb < 1000) applyStimulusLook(1'b1);
    checkOutput("b_fs_lat", kb - 1, 56);
    while (kb < 220) applyStimulusLook(1'b1);
    checkOutput("b2_hs_first", hs_first, 3);
    checkOutput("b2_de_first", de_first, 59);
    checkOutput("b2_hs_cnt", cb_hs, 12);
    checkOutput("b2_vs_cnt", cb_vs, 26);

    $display("[TB] instance C: default timing to first visible line");
    checkOutput("c_rst_hs", hsync_c, 1'b1);
    checkOutput("c_rst_vs", vsync_c, 1'b0);
    checkOutput("c_rst_de", de_c, 1'b0);
    checkOutput("c_rst_pix", {pix_r_c, pix_g_c, pix_b_c}, 0);
    checkOutput("c_rst_xy", {curr_x_c, curr_y_c, coord_valid_c}, 0);
    hs_c = 0; vs_c = 0; de_c_cnt = 0; dfirst_c = -1; ffirst_c = -1;
    rst_n_c = 1'b1;
    pix_en_c = 1'b1;
    for (int k = 1; k <= 61312; k++) begin
      @(posedge clk);
      #1;
      if (!hsync_c) hs_c++;
      if (vsync_c) vs_c++;
      if (de_c) de_c_cnt++;
      if (de_c && dfirst_c < 0) dfirst_c = k;
      if (frame_start_c && ffirst_c < 0) ffirst_c = k;
    end
    checkOutput("c_fs_lat", ffirst_c, 59408);
    checkOutput("c_de_first", dfirst_c, 59410);
    checkOutput("c_hs_cnt", hs_c, 5016);
    checkOutput("c_vs_cnt", vs_c, 5712);
    checkOutput("c_de_cnt", de_c_cnt, 1440);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator with look-ahead pixel coordinates and a registered, blanked RGB output stage.
- Sits between the game/pixel renderer and the board VGA pins.
- Generalises the fixed 1440x900 generator with:
  - configurable porches and sync widths
  - configurable sync polarity and colour depth
  - pixel clock enable
  - coordinate look-ahead for renderers with pipeline latency
  - data-enable, frame-start and line-start strobes

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, horizontal sync width
- H_BP, 232, horizontal back porch
- V_ACTIVE, 900, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 28, vertical back porch
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 1, vsync active level
- CW, 4, bits per colour channel
- LOOKAHEAD, 1, pixel-enable ticks between coordinate issue and colour sampling (legal range 0..4)
- XW, 11, width of curr_x (must hold H_ACTIVE-1)
- YW, 10, width of curr_y (must hold V_ACTIVE-1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel tick; the timing advances only on cycles where it is 1
- red_in  in  CW  renderer red for the pixel issued LOOKAHEAD ticks earlier
- gre_in  in  CW  renderer green
- blu_in  in  CW  renderer blue
- pix_r  out  CW  registered red, forced 0 outside active area
- pix_g  out  CW  registered green
- pix_b  out  CW  registered blue
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- de  out  1  registered data enable, aligned with pix_*
- curr_x  out  XW  issued column, 0..H_ACTIVE-1
- curr_y  out  YW  issued row, 0..V_ACTIVE-1
- coord_valid  out  1  curr_x/curr_y address a visible pixel
- frame_start  out  1  one-tick pulse at issue of pixel (0,0)
- line_start  out  1  one-tick pulse at issue of x=0 on each active line

Behaviour:
- Clock, reset and tick:
  - One clock, clk. rst_n is synchronous and active-low.
  - All state changes occur only on the rising edge of clk with pix_en=1, except reset.
- Reset (rst_n=0 at an edge):
  - hcount=0, vcount=0, delay line cleared.
  - hsync=~HS_POL, vsync=~VS_POL, de=0, pix_*=0.
  - curr_x=0, curr_y=0, coord_valid=0, frame_start=0, line_start=0.
  - Reset mid-frame aborts the frame. The first tick after release restarts at hcount=0, vcount=0.
- Counters:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
  - hcount runs 0..H_TOTAL-1 and wraps to 0.
  - vcount increments when hcount wraps, runs 0..V_TOTAL-1, and wraps to 0 when both are at terminal count.
  - Line order: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch. Vertical order is the same.
- Issue stage (combinational from counters):
  - coord_valid=1 iff both hcount and vcount are in their active windows.
  - When coord_valid=1: curr_x = hcount-(H_SYNC+H_BP) and curr_y = vcount-(V_SYNC+V_BP). Otherwise both are 0.
  - frame_start = coord_valid & curr_x==0 & curr_y==0 & pix_en.
  - line_start = coord_valid & curr_x==0 & pix_en.
- Delay line:
  - Raw hsync_i, vsync_i and active_i are shifted through LOOKAHEAD stages, advancing on pix_en.
  - Colour inputs arrive aligned with the delay-line output.
- Output stage (one more register, loaded on pix_en):
  - hsync = HS_POL when the delayed hsync_i=1, else ~HS_POL. vsync uses VS_POL the same way.
  - de = delayed active_i.
  - pix_* = de-window ? {r,g,b}_in : 0.
- Latency:
  - Coordinate to pix_* output: LOOKAHEAD+1 ticks.
  - Syncs carry the same delay, so sync and colour relationships are identical for any LOOKAHEAD.
- pix_en:
  - When pix_en=0, all registered outputs hold.
  - Strobes are 0 on any cycle with pix_en=0.
- Defaults produce a 1904x932 total frame, exactly 1440x900 visible, hsync active low for 152 ticks, vsync active high for 3 lines.

Test Plan:
- Default parameters, pix_en=1, run 2 frames:
  - hsync low for exactly 152 of every 1904 ticks.
  - vsync high for 3x1904 ticks per 932-line frame.
  - de high 1440x900 ticks per frame.
- LOOKAHEAD=2, red_in driven with a registered copy of curr_x[3:0] delayed 2 ticks:
  - pix_r equals column mod 16 for every de=1 tick; no off-by-one at x=0 or x=1439.
- Reset at hcount=1000, vcount=500, held 3 cycles:
  - All outputs at reset values during the hold.
  - After release: first frame_start after exactly (H_SYNC+H_BP)+(V_SYNC+V_BP)*H_TOTAL ticks.
- pix_en toggled 1-of-4:
  - All period counts from the first scenario scale by 4.
  - Outputs stable on disabled cycles.
  - Each strobe is a single clk wide.
- Small config (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, VS_POL=0, LOOKAHEAD=0):
  - Line 14 ticks, frame 7 lines.
  - hsync high ticks 0..2; vsync low line 0.
  - curr_x wraps 7->0 with line_start; curr_y 3->0 with frame_start.
- Input colour nonzero constant (all channels 0xF):
  - pix_* = 0 on every de=0 tick, including porch edges.
